// File: rtl/spec_bram_pkg.sv
// spec_bram_pkg: writer defaults, BRAM word-width derivation and FSM states.
// Build option SPEC_PHASE_STORE_EN widens the stored word to {phase, magnitude}.
package spec_bram_pkg;

    localparam int BINS_DEF  = 256;
    localparam int MAG_W_DEF = 24;
    localparam int PH_W_DEF  = 24;

`ifdef SPEC_PHASE_STORE_EN
    localparam bit PHASE_STORE = 1'b1;
`else
    localparam bit PHASE_STORE = 1'b0;
`endif

    function automatic int bram_dw(input int mag_w, input int ph_w);
        return PHASE_STORE ? mag_w + ph_w : mag_w;
    endfunction

    localparam int BRAM_DW_DEF = bram_dw(MAG_W_DEF, PH_W_DEF);

    typedef enum logic {
        FILL,
        WAIT_FREE
    } wr_state_e;

endpackage

// File: rtl/spec_bram_writer_peak.sv
// peak_tracker: running max/argmax over a frame, latched at frame end.
// Strict compare keeps the lowest bin on ties; a cleared tracker reports bin 0.
module peak_tracker #(
    parameter int MAG_W = 24,
    parameter int BIN_W = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             update,
    input  logic             latch,
    input  logic [MAG_W-1:0] mag,
    input  logic [BIN_W-1:0] bin,
    output logic [MAG_W-1:0] peak_mag,
    output logic [BIN_W-1:0] peak_bin
);

    logic [MAG_W-1:0] run_mag;
    logic [BIN_W-1:0] run_bin;
    logic [MAG_W-1:0] cand_mag;
    logic [BIN_W-1:0] cand_bin;

    // Candidate includes the current beat so the final beat counts at latch time
    always_comb begin
        cand_mag = run_mag;
        cand_bin = run_bin;
        if (update && (mag > run_mag)) begin
            cand_mag = mag;
            cand_bin = bin;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_mag  <= '0;
            run_bin  <= '0;
            peak_mag <= '0;
            peak_bin <= '0;
        end else begin
            if (clear) begin
                run_mag <= '0;
                run_bin <= '0;
            end else begin
                run_mag <= cand_mag;
                run_bin <= cand_bin;
            end
            if (latch) begin
                peak_mag <= cand_mag;
                peak_bin <= cand_bin;
            end
        end
    end

endmodule

// File: rtl/spec_bram_writer.sv
// spec_bram_writer: writes CORDIC magnitude/phase frames into a ping-pong BRAM.
// Define SPEC_PHASE_STORE_EN to store {phase, magnitude}; otherwise magnitude only.
module spec_bram_writer
    import spec_bram_pkg::*;
#(
    parameter int  BINS    = BINS_DEF,
    parameter int  MAG_W   = MAG_W_DEF,
    parameter int  PH_W    = PH_W_DEF,
    localparam int BIN_W   = $clog2(BINS),
    localparam int ADDR_W  = BIN_W + 1,
    localparam int BRAM_DW = bram_dw(MAG_W, PH_W)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [MAG_W+PH_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [BRAM_DW-1:0]    bram_din,
    output logic                  bram_we,
    output logic                  frame_avail,
    output logic                  rd_bank,
    input  logic                  rd_done,
    output logic                  frame_done,
    output logic [MAG_W-1:0]      peak_mag,
    output logic [BIN_W-1:0]      peak_bin,
    output logic                  err_short,
    output logic                  err_long
);

    wr_state_e        state;
    wr_state_e        state_d;
    logic             wr_bank;
    logic             wr_bank_d;
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_d;
    logic [BIN_W-1:0] bin_cnt;
    logic             ready_d;
    logic             accept;
    logic             at_last_bin;
    logic             frame_end;
    logic             rd_ok;
    logic [MAG_W-1:0] beat_mag;
    logic [BRAM_DW-1:0] beat_data;

    assign beat_mag = s_axis_tdata[MAG_W-1:0];

`ifdef SPEC_PHASE_STORE_EN
    assign beat_data = s_axis_tdata[MAG_W+PH_W-1:0];
`else
    logic unused_phase;
    assign beat_data    = s_axis_tdata[MAG_W-1:0];
    assign unused_phase = ^s_axis_tdata[MAG_W+PH_W-1:MAG_W];
`endif

    assign accept      = s_axis_tvalid && s_axis_tready;
    assign at_last_bin = (bin_cnt == BIN_W'(BINS - 1));
    assign frame_end   = accept && (s_axis_tlast || at_last_bin);
    assign rd_ok       = rd_done && (|bank_full);
    assign frame_avail = |bank_full;
    assign wr_bank_d   = wr_bank ^ frame_end;

    // Set and clear never target the same bank: the write bank is never full
    always_comb begin
        bank_full_d = bank_full;
        if (rd_ok) begin
            bank_full_d[rd_bank] = 1'b0;
        end
        if (frame_end) begin
            bank_full_d[wr_bank] = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            FILL: begin
                if (frame_end && bank_full_d[~wr_bank]) begin
                    state_d = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (!bank_full[wr_bank]) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Ready is registered from next-state values, so tvalid never reaches it
    assign ready_d = (state_d == FILL) && !bank_full_d[wr_bank_d];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= FILL;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            bank_full     <= 2'b00;
            bin_cnt       <= '0;
            s_axis_tready <= 1'b0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
        end else begin
            state         <= state_d;
            wr_bank       <= wr_bank_d;
            bank_full     <= bank_full_d;
            s_axis_tready <= ready_d;
            if (rd_ok) begin
                rd_bank <= ~rd_bank;
            end
            if (accept) begin
                bin_cnt <= frame_end ? '0 : bin_cnt + BIN_W'(1);
            end
            if (frame_end && s_axis_tlast && !at_last_bin) begin
                err_short <= 1'b1;
            end
            if (frame_end && !s_axis_tlast) begin
                err_long <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            frame_done <= 1'b0;
        end else begin
            bram_we    <= accept;
            frame_done <= frame_end;
            if (accept) begin
                bram_addr <= {wr_bank, bin_cnt};
                bram_din  <= beat_data;
            end
        end
    end

    peak_tracker #(
        .MAG_W (MAG_W),
        .BIN_W (BIN_W)
    ) u_peak (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clear    (frame_end),
        .update   (accept),
        .latch    (frame_end),
        .mag      (beat_mag),
        .bin      (bin_cnt),
        .peak_mag (peak_mag),
        .peak_bin (peak_bin)
    );

endmodule

// File: doc/spec_bram_writer.md
# spec_bram_writer

Consumes the CORDIC (translate mode) magnitude/phase stream that follows the half-spectrum trimmer and writes each 256-bin frame into a ping-pong BRAM region for the processor to read. It counts bins, checks frame framing against `tlast`, tracks the per-frame peak bin, and applies backpressure to the CORDIC when both banks hold unread frames.

## Interface

**Parameters**
- `BINS`, 256: bins per frame; power of two.
- `MAG_W`, 24: magnitude width, taken from `s_axis_tdata[MAG_W-1:0]`.
- `PH_W`, 24: phase width, taken from `s_axis_tdata[MAG_W+PH_W-1:MAG_W]`.
- `ADDR_W`: localparam, `log2(BINS)+1`. The MSB is the bank bit.

**Ports**
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 48: CORDIC output, `{phase, magnitude}`.
- `s_axis_tvalid` in 1: AXIS valid.
- `s_axis_tlast` in 1: end of frame, expected at bin `BINS-1`.
- `s_axis_tready` out 1: AXIS ready.
- `bram_addr` out ADDR_W: `{wr_bank, bin}`.
- `bram_din` out BRAM_DW: write data (width set in Configuration).
- `bram_we` out 1: write enable.
- `frame_avail` out 1: at least one bank holds an unread frame.
- `rd_bank` out 1: bank the reader should consume (the oldest full bank).
- `rd_done` in 1: single-cycle pulse; releases `rd_bank`.
- `frame_done` out 1: single-cycle pulse at the end of each written frame.
- `peak_mag` out MAG_W: peak magnitude of the last completed frame.
- `peak_bin` out log2(BINS): bin index of that peak.
- `err_short` out 1: sticky; a `tlast` arrived before bin `BINS-1`.
- `err_long` out 1: sticky; bin `BINS-1` was accepted without `tlast`.

## Operation

**State machine**
- `FILL`: `s_axis_tready = !bank_full[wr_bank]`.
- `WAIT_FREE`: `s_axis_tready = 0`.
- Reset enters `FILL` with `wr_bank = 0`.

**Per accepted beat** (`tvalid && tready`)
- Write data to `{wr_bank, bin_cnt}`.
- Increment `bin_cnt`.
- Update the running peak.

**Frame end**
- Triggered by an accepted beat with `tlast`, or one with `bin_cnt == BINS-1`, whichever comes first.
- On frame end:
  - set `bank_full[wr_bank]`;
  - toggle `wr_bank`;
  - clear `bin_cnt`;
  - latch `peak_mag`/`peak_bin`;
  - reset the running peak.
- If the new `wr_bank` is still full, go to `WAIT_FREE`.
- `tlast` with `bin_cnt < BINS-1`: the frame ends short and `err_short` sets. Unwritten bins keep stale data.
- `bin_cnt == BINS-1` without `tlast`: the frame ends anyway and `err_long` sets. Following beats start a new frame.

**Read side**
- `frame_avail = |bank_full`.
- `rd_done` clears `bank_full[rd_bank]` and toggles `rd_bank`.
- `rd_done` while `!frame_avail` is ignored.
- `WAIT_FREE` → `FILL` in the cycle after `bank_full[wr_bank]` clears.

**Boundary conditions**
- Frame end and `rd_done` in the same cycle: both take effect. The set and the clear hit different banks by construction.
- Peak compare is a strict `>`, so the lowest bin wins ties. An all-zero frame reports `peak_bin = 0`.
- Phase is never used arithmetically; magnitude is compared as unsigned.

## Timing

**Reset values**
- All outputs 0, including `bram_we`, `frame_done`, the peaks, and the errors.
- `rd_bank = 0`.
- Reset mid-frame discards the partial frame and both bank flags.

**Latencies**
- BRAM port outputs are registered: `bram_we`, `addr`, and `din` appear 1 cycle after the accepted beat.
- `frame_done` and the updated `peak_*` appear in the same cycle as the final write.
- `s_axis_tready` is registered; it drops the cycle after the frame end that fills the second bank.
- `frame_avail` rises with `frame_done`.
- `rd_done` → `s_axis_tready` high: 2 cycles.

**Throughput**
- One beat per cycle while a bank is free.
- No combinational path from `s_axis_tvalid` to `s_axis_tready`.

## Configuration

- `SPEC_PHASE_STORE_EN` defined: `BRAM_DW = MAG_W+PH_W` and `bram_din = {phase, magnitude}`.
- Not defined: `BRAM_DW = MAG_W` and `bram_din = magnitude`. The phase bits are ignored.
- Framing, peak, and handshake behaviour are identical in both builds.

## Structure

- Package `spec_bram_pkg` holds:
  - the `BINS`, `MAG_W`, `PH_W` defaults;
  - the `BRAM_DW` derivation;
  - the state enum `{FILL, WAIT_FREE}`.
- One sub-module, `peak_tracker`, holds the running max/argmax with `clear`, `update`, and `latch` controls.

## Test plan

- **Two frames, no read:** two 256-beat frames with `mag = bin`, then a third frame offered → `peak = 255 @ bin 255` for both; `frame_done` ×2; `s_axis_tready = 0` from cycle 513 onward.
- **Release:** after the above, pulse `rd_done` → `rd_bank` 0→1; `tready` high 2 cycles later; the third frame is written to addresses 0..255.
- **Short frame:** `tlast` at bin 99 → `err_short = 1`; `frame_done` at the 100th write; the next frame starts at bin 0 in the other bank.
- **Long frame:** 300 beats with no `tlast` → `err_long = 1`; frame end at beat 256; beats 257–300 go to bank 1 at bins 0–43.
- **Tie and zero:** magnitude 0x00FFFF at bins 10 and 200 → `peak_bin = 10`. An all-zero frame → `peak_mag = 0`, `peak_bin = 0`.
- **Reset mid-frame:** deassert `aresetn` at bin 128 → all outputs 0; the next frame writes from address 0; `frame_avail = 0`.
